// File: rtl/fft_twiddle_agu.sv
// Radix-2 8-point FFT operand/twiddle address sequencer with writeback drain.
// Define FFT_AGU_STALL_CNT_EN to add the o_stall_cnt ready-stall counter.
module fft_twiddle_agu (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_ready,
  input  logic        i_wb,
  output logic        o_valid,
  output logic [2:0]  o_addr_top,
  output logic [2:0]  o_addr_bot,
  output logic [1:0]  o_tw_addr,
  output logic [1:0]  o_stage,
  output logic        o_busy,
  output logic        o_done
`ifdef FFT_AGU_STALL_CNT_EN
  ,
  output logic [15:0] o_stall_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  typedef struct packed {
    logic [2:0] top;
    logic [2:0] bot;
    logic [1:0] k;
  } issue_t;

  // h = 1<<s, pos = b mod h, top = (b/h)*2h + pos, k = pos*(4/h)
  function automatic issue_t calc(
    input logic [1:0] s,
    input logic [1:0] b
  );
    issue_t     r;
    logic [2:0] h;
    logic [1:0] pos;
    logic [2:0] bb;
    h     = 3'd1 << s;
    pos   = b & (h[1:0] - 2'd1);
    bb    = {1'b0, b};
    r.top = ((bb >> s) << (s + 2'd1)) + {1'b0, pos};
    r.bot = r.top + h;
    r.k   = pos << (2'd2 - s);
    return r;
  endfunction

  state_t     state_q, state_d;
  logic [1:0] stage_q, stage_d;
  logic [1:0] b_q, b_d;
  logic [2:0] cnt_q, cnt_d;
  logic       valid_q;
  logic       busy_q;
  logic       done_q;
  logic [2:0] top_q;
  logic [2:0] bot_q;
  logic [1:0] k_q;
  logic       hs;
  issue_t     nxt;

  assign hs = valid_q & i_ready;

  always_comb begin
    cnt_d = cnt_q;
    if (hs && !i_wb) begin
      cnt_d = cnt_q + 3'd1;
    end else if (!hs && i_wb && cnt_q != 3'd0) begin
      cnt_d = cnt_q - 3'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    b_d     = b_q;
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = ISSUE;
          stage_d = 2'd0;
          b_d     = 2'd0;
        end
      end
      ISSUE: begin
        if (hs) begin
          if (b_q == 2'd3) begin
            state_d = DRAIN;
          end else begin
            b_d = b_q + 2'd1;
          end
        end
      end
      DRAIN: begin
        if (cnt_q == 3'd0) begin
          if (stage_q == 2'd2) begin
            state_d = DONE;
          end else begin
            state_d = ISSUE;
            stage_d = stage_q + 2'd1;
            b_d     = 2'd0;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    nxt = calc(stage_d, b_d);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      stage_q <= 2'd0;
      b_q     <= 2'd0;
      cnt_q   <= 3'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      top_q   <= 3'd0;
      bot_q   <= 3'd0;
      k_q     <= 2'd0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      valid_q <= (state_d == ISSUE);
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
      if (state_d == ISSUE) begin
        top_q <= nxt.top;
        bot_q <= nxt.bot;
        k_q   <= nxt.k;
      end
    end
  end

  assign o_valid    = valid_q;
  assign o_addr_top = top_q;
  assign o_addr_bot = bot_q;
  assign o_tw_addr  = k_q;
  assign o_stage    = stage_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;

`ifdef FFT_AGU_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_q <= 16'd0;
    end else if (state_q == IDLE && i_start) begin
      stall_q <= 16'd0;
    end else if (valid_q && !i_ready && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign o_stall_cnt = stall_q;
`endif

endmodule
